// File: rtl/reg_writeback.sv
// reg_writeback: writeback stage in front of a 32x32 register file.
// Merges a single-cycle ALU result path and a valid/ready load path into the
// register file's single write port. Loads that cannot be written at once wait
// in a small FIFO. A starvation guard stalls the ALU for one cycle so a queued
// load always makes progress. Writes to x0 are consumed but never issued.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data     ALU result (no backpressure)
//   alu_stall                     registered: upstream holds alu_valid=0 next cycle
//   mem_valid/mem_rd/mem_data     load result offer
//   mem_ready                     combinational: FIFO not full
//   reg_write/waddr/wdata         registered register-file write port
//   lq_count                      load FIFO occupancy
//   proto_err                     sticky: alu_valid seen during alu_stall
module reg_writeback #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int LQ_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        alu_valid,
    input  logic [ADDR_W-1:0]           alu_rd,
    input  logic [DATA_W-1:0]           alu_data,
    output logic                        alu_stall,
    input  logic                        mem_valid,
    output logic                        mem_ready,
    input  logic [ADDR_W-1:0]           mem_rd,
    input  logic [DATA_W-1:0]           mem_data,
    output logic                        reg_write,
    output logic [ADDR_W-1:0]           waddr,
    output logic [DATA_W-1:0]           wdata,
    output logic [$clog2(LQ_DEPTH):0]   lq_count,
    output logic                        proto_err
);

    localparam int CW = $clog2(LQ_DEPTH) + 1;
    localparam int PW = $clog2(LQ_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT) + 1;

    // FIFO storage and pointers; power-of-two depth lets pointers wrap freely
    logic [ADDR_W-1:0] q_rd   [LQ_DEPTH];
    logic [DATA_W-1:0] q_data [LQ_DEPTH];
    logic [PW-1:0]     rptr, wptr;
    logic [CW-1:0]     count;
    logic [SW-1:0]     starve_cnt;

    logic              empty, accept, pop, bypass, push, at_limit;
    logic              nxt_we;
    logic [ADDR_W-1:0] nxt_rd;
    logic [DATA_W-1:0] nxt_data;

    always_comb begin
        empty     = (count == '0);
        mem_ready = (count < CW'(LQ_DEPTH));
        accept    = mem_valid && mem_ready;
        // ALU has absolute priority; queued loads go before a same-cycle load
        pop       = !alu_valid && !empty;
        bypass    = !alu_valid && empty && accept;
        push      = accept && !bypass;
        at_limit  = (starve_cnt == SW'(STARVE_LIMIT - 1));

        nxt_rd   = '0;
        nxt_data = '0;
        if (alu_valid) begin
            nxt_rd   = alu_rd;
            nxt_data = alu_data;
        end else if (pop) begin
            nxt_rd   = q_rd[rptr];
            nxt_data = q_data[rptr];
        end else if (bypass) begin
            nxt_rd   = mem_rd;
            nxt_data = mem_data;
        end
        // x0 entries are consumed but never reach the register file
        nxt_we = (alu_valid || pop || bypass) && (nxt_rd != '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wptr]   <= mem_rd;
            q_data[wptr] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rptr       <= '0;
            wptr       <= '0;
            count      <= '0;
            starve_cnt <= '0;
            alu_stall  <= 1'b0;
            proto_err  <= 1'b0;
            reg_write  <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // Address/data hold while idle; only the enable drops
            reg_write <= nxt_we;
            if (nxt_we) begin
                waddr <= nxt_rd;
                wdata <= nxt_data;
            end

            // Non-empty and not popping implies the ALU won this cycle;
            // the counter saturates at the limit
            if (empty || pop)
                starve_cnt <= '0;
            else if (!at_limit)
                starve_cnt <= starve_cnt + SW'(1);

            // One-cycle pulse; never re-armed directly out of a stall cycle
            alu_stall <= at_limit && alu_valid && !empty && !alu_stall;
            proto_err <= proto_err | (alu_valid & alu_stall);
        end
    end

    assign lq_count = count;

endmodule

// File: tb/tb_reg_writeback.sv
// Testbench for reg_writeback: directed steps from the test plan followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_reg_writeback;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int LQ_DEPTH = 2;
    localparam int STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_stall;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              reg_write;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [$clog2(LQ_DEPTH):0] lq_count;
    logic              proto_err;

    reg_writeback #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .LQ_DEPTH(LQ_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .alu_stall(alu_stall),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_data(mem_data),
        .reg_write(reg_write), .waddr(waddr), .wdata(wdata),
        .lq_count(lq_count), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // Reference model: pending loads as a queue, outputs as plain variables
    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t        q[$];
    bit          m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    int          m_cnt;
    bit          m_stall;
    bit          m_perr;
    bit          known;

    int checks;
    int errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_write(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
        m_we = (rd != 0);
        if (rd != 0) begin
            m_addr = rd;
            m_data = d;
        end
    endtask

    // One clock cycle: drive, check combinational ready, step the model,
    // cross the edge, compare registered outputs.
    task automatic cyc(input bit rst, input bit av, input logic [ADDR_W-1:0] ard,
                       input logic [DATA_W-1:0] ad, input bit mv,
                       input logic [ADDR_W-1:0] mrd, input logic [DATA_W-1:0] md);
        bit   ready, acc, nonempty, popped, bypassed, nstall;
        ent_t e;
        reset = rst; alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        #2;
        ready = (q.size() < LQ_DEPTH);
        if (known) chk("mem_ready", {31'b0, mem_ready}, {31'b0, ready});
        acc = mv && ready;
        if (rst) begin
            q.delete();
            m_we = 0; m_addr = '0; m_data = '0;
            m_cnt = 0; m_stall = 0; m_perr = 0;
        end else begin
            nonempty = (q.size() != 0);
            popped = 0; bypassed = 0; nstall = 0;
            if (av && m_stall) m_perr = 1;
            if (av) begin
                mdl_write(ard, ad);
                if (nonempty) begin
                    if (m_cnt == STARVE_LIMIT - 1) nstall = !m_stall;
                    else m_cnt++;
                end
            end else if (nonempty) begin
                e = q.pop_front();
                mdl_write(e.rd, e.d);
                popped = 1;
            end else if (acc) begin
                mdl_write(mrd, md);
                bypassed = 1;
            end else begin
                m_we = 0;
            end
            if (acc && !bypassed) begin
                e.rd = mrd; e.d = md;
                q.push_back(e);
            end
            if (!nonempty || popped) m_cnt = 0;
            m_stall = nstall;
        end
        @(posedge clk);
        #1;
        known = 1;
        chk("reg_write", {31'b0, reg_write}, {31'b0, m_we});
        if (m_we) begin
            chk("waddr", {27'b0, waddr}, {27'b0, m_addr});
            chk("wdata", wdata, m_data);
        end
        chk("lq_count", {30'b0, lq_count}, q.size());
        chk("alu_stall", {31'b0, alu_stall}, {31'b0, m_stall});
        chk("proto_err", {31'b0, proto_err}, {31'b0, m_perr});
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int  li;
        bit  seen, was_stall, will_acc;
        logic [ADDR_W-1:0] lrd;
        checks = 0; errors = 0; known = 0;
        m_we = 0; m_addr = '0; m_data = '0; m_cnt = 0; m_stall = 0; m_perr = 0;

        // Reset for 3 cycles, then release
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rst_waddr", {27'b0, waddr}, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        idle();
        chk("rst_mem_ready", {31'b0, mem_ready}, 32'd1);

        // Plain ALU write
        cyc(0, 1, 5'd5, 32'h0000_00FF, 0, 0, 0);
        chk("alu_rd5", {reg_write, 26'b0, waddr, 32'h0} != 0 ? {27'b0, waddr} : 32'hFFFF, 32'd5);

        // Load bypass with empty FIFO
        cyc(0, 0, 0, 0, 1, 5'd1, 32'h2222_22FF);
        chk("bypass_data", wdata, 32'h2222_22FF);
        idle();

        // ALU and load in the same cycle: ALU first, load queued then written
        cyc(0, 1, 5'd3, 32'h3333_0003, 1, 5'd4, 32'h4444_0004);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("queued_rd4", {27'b0, waddr}, 32'd4);
        idle();

        // Continuous ALU, three loads offered: starvation guard must fire
        li = 0; seen = 0;
        for (int c = 0; c < 14; c++) begin
            lrd = 5'(10 + li);
            will_acc = (li < 3) && (q.size() < LQ_DEPTH);
            was_stall = m_stall;
            cyc(0, !m_stall, 5'(20 + c), 32'(32'hA000_0000 + c),
                li < 3, lrd, 32'(32'hB000_0000 + li));
            if (will_acc) li++;
            if (was_stall && !seen) begin
                chk("stall_writes_rd10", {reg_write, 26'b0, waddr}, {1'b1, 26'b0, 5'd10});
                seen = 1;
            end
        end
        chk("stall_seen", {31'b0, seen}, 32'd1);
        repeat (3) idle();

        // x0 writes from the ALU and from a queued load
        cyc(0, 1, 5'd0, 32'hDEAD_BEEF, 0, 0, 0);
        cyc(0, 1, 5'd7, 32'h7777_7777, 1, 5'd0, 32'h0BAD_0000);
        chk("x0_queued", {30'b0, lq_count}, 32'd1);
        idle();
        chk("x0_popped", {30'b0, lq_count}, 32'd0);

        // Protocol violation during alu_stall, then reset with loads queued
        for (int c = 0; c < 7; c++)
            cyc(0, 1, 5'(2 + c), 32'(c), c < 2, 5'(13 + c), 32'(32'hC000_0000 + c));
        chk("proto_err_set", {31'b0, proto_err}, 32'd1);
        chk("two_queued", {30'b0, lq_count}, 32'd2);
        cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (3) idle();
        chk("post_rst_perr", {31'b0, proto_err}, 32'd0);

        // Randomized traffic, upstream honours alu_stall
        for (int c = 0; c < 400; c++) begin
            cyc(($urandom_range(0, 99) == 0),
                !m_stall && ($urandom_range(0, 2) != 0),
                5'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 1) == 1),
                5'($urandom_range(0, 7)), $urandom);
        end
        repeat (4) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Writeback stage directly upstream of the 32x32 register file.
- Merges two result sources into the register file's single write port (reg_write/waddr/wdata):
  - the ALU path: single-cycle, no backpressure;
  - the load path: valid/ready, buffered in a small FIFO.
- Arbitrates between the sources, drops x0 writes, and prevents load starvation.

Parameters:
- DATA_W, 32, result/write data width.
- ADDR_W, 5, register address width.
- LQ_DEPTH, 2, load FIFO depth; power of two, >= 2.
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO head may lose arbitration before alu_stall asserts.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_stall  out  1  upstream must hold alu_valid=0 in the following cycle.
- mem_valid  in  1  load result offered.
- mem_ready  out  1  FIFO can accept (combinational: count < LQ_DEPTH).
- mem_rd  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load data.
- reg_write  out  1  registered write enable to the register file.
- waddr  out  ADDR_W  registered write address.
- wdata  out  DATA_W  registered write data.
- lq_count  out  $clog2(LQ_DEPTH)+1  FIFO occupancy.
- proto_err  out  1  sticky: alu_valid seen while alu_stall was in force.

Behaviour:
- Reset: reg_write=0, waddr=0, wdata=0, FIFO empty, lq_count=0, starve counter=0, alu_stall=0, proto_err=0. mem_ready is 1 in the cycle after reset deasserts. Reset mid-operation discards all FIFO contents and any pending write.
- Handshakes:
  - Load accepted when mem_valid && mem_ready.
  - mem_ready depends only on the current count; there is no push-on-full, even when a pop happens in the same cycle.
- Arbitration (per cycle, selects the source for the output register at the next edge):
  1. alu_valid=1 -> ALU wins.
  2. Else FIFO non-empty -> pop head.
  3. Else an accepted load in this same cycle bypasses the FIFO straight to the output.
  4. Else nothing is selected; reg_write=0 next cycle.
- If the ALU wins while a load is accepted, the load is pushed into the FIFO.
- Latency: exactly 1 cycle from the selected source to reg_write/waddr/wdata. Outputs hold their values when idle; only reg_write drops.
- x0 handling: a selected entry with rd=0 is consumed (popped or accepted) but yields reg_write=0.
- Starvation guard:
  - Counter increments each cycle the FIFO is non-empty and the ALU wins.
  - Counter clears on any pop, and when the FIFO is empty.
  - alu_stall asserts (registered) when counter reaches STARVE_LIMIT-1 and the ALU wins again. It stays high for exactly 1 cycle.
  - During that cycle the FIFO head is guaranteed to be written.
  - alu_valid=1 while alu_stall=1:
    - the ALU still wins;
    - proto_err sets and stays set until reset;
    - the counter saturates.
- Ordering: writes reach the register file in commit-cycle order. Same-rd hazards between the two sources are upstream's responsibility.
- lq_count updates on the edge: +1 on push, -1 on pop, unchanged on push+pop or bypass.

Test Plan:
- Reset held 3 cycles, then released -> reg_write=0, lq_count=0, mem_ready=1, proto_err=0; then alu_valid with rd=5, data=0x000000FF -> next cycle reg_write=1, waddr=5, wdata=0x000000FF.
- mem_valid alone with rd=1, data=0x222222FF, FIFO empty -> bypass; next cycle waddr=1, wdata=0x222222FF; lq_count stays 0.
- ALU rd=3 and mem rd=4 in the same cycle -> cycle+1 writes rd3, cycle+2 writes rd4; lq_count goes 1 then 0.
- alu_valid held high continuously, three loads offered (rd 10, 11, 12) -> first two accepted, then mem_ready=0 with lq_count=2. alu_stall pulses after STARVE_LIMIT ALU wins; during the pulse (alu_valid dropped) rd10 is written.
- Writes to x0 from the ALU (data 0xDEADBEEF) and from a load -> reg_write stays 0; the load entry is popped and lq_count decrements.
- Drive alu_valid=1 during the alu_stall cycle -> proto_err=1 and stays set. Then synchronous reset with 2 loads queued -> FIFO empty, proto_err=0, and no write is issued afterwards.
